// File: rtl/ols_pkg.sv
// Shared types and constants for the capture controller: FSM states and the
// conversion from a 16-bit length code to a sample count.
package ols_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        DELAY,
        READ_ADDR,
        READ_WAIT,
        SEND
    } state_t;

    localparam int SAMPLES_PER_CODE = 4;
    // (0xFFFF + 1) * 4 = 2**18 needs 19 bits
    localparam int SAMPLES_W = 19;

    function automatic logic [SAMPLES_W-1:0] code_to_samples(input logic [15:0] code);
        return (SAMPLES_W'(code) + SAMPLES_W'(1)) * SAMPLES_W'(SAMPLES_PER_CODE);
    endfunction

endpackage

// File: rtl/capture_counter.sv
// Loadable down-counter with zero flag; load has priority over decrement and
// the count saturates at zero.
module capture_counter #(
    parameter int W = 19
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/capture_controller.sv
// Logic-analyser capture controller: ring-buffer sampling until a trigger plus
// post-trigger delay, then newest-first readout to the SPI transmitter.
module capture_controller
    import ols_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_reset,
    input  logic              cmd_run,
    input  logic [15:0]       read_count,
    input  logic [15:0]       delay_count,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    input  logic              trigger,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              tx_valid,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_ready,
    output logic              data_ready,
    output logic              arm_led,
    output logic              trigger_led
);

    localparam int CNT_W = (ADDR_W + 1 > SAMPLES_W) ? ADDR_W + 1 : SAMPLES_W;
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(1) << ADDR_W;

    function automatic logic [CNT_W-1:0] clamp_len(input logic [15:0] code);
        logic [CNT_W-1:0] n;
        n = CNT_W'(code_to_samples(code));
        return (n > DEPTH) ? DEPTH : n;
    endfunction

    state_t state, state_nxt;

    logic              rst;
    logic              start, wr_en, capture;
    logic              dly_load, dly_dec, dly_zero;
    logic              rd_load, rd_dec, rd_zero;
    logic [CNT_W-1:0]  dly_val, dly_cnt, rd_cnt;
    logic [15:0]       rc_q, dc_q;
    logic [ADDR_W-1:0] wptr, rptr;

    assign rst = reset | cmd_reset;

    always_ff @(posedge clock) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        wr_en     = 1'b0;
        capture   = 1'b0;
        dly_load  = 1'b0;
        dly_val   = '0;
        dly_dec   = 1'b0;
        rd_load   = 1'b0;
        rd_dec    = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_run) begin
                    start     = 1'b1;
                    state_nxt = ARMED;
                end
            end
            ARMED: begin
                wr_en = sample_valid;
                if (trigger) begin
                    // a coincident sample is already the first delay sample
                    dly_load  = 1'b1;
                    dly_val   = clamp_len(dc_q) - CNT_W'(sample_valid);
                    state_nxt = DELAY;
                end
            end
            DELAY: begin
                wr_en   = sample_valid && !dly_zero;
                dly_dec = sample_valid;
                if (dly_zero || (sample_valid && dly_cnt == CNT_W'(1))) begin
                    rd_load   = 1'b1;
                    state_nxt = READ_ADDR;
                end
            end
            READ_ADDR: state_nxt = READ_WAIT;
            READ_WAIT: begin
                capture   = 1'b1;
                state_nxt = SEND;
            end
            SEND: begin
                if (tx_ready) begin
                    rd_dec    = 1'b1;
                    state_nxt = (rd_zero || rd_cnt == CNT_W'(1)) ? IDLE : READ_ADDR;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            rc_q    <= '0;
            dc_q    <= '0;
            tx_data <= '0;
        end else begin
            if (start) begin
                rc_q <= read_count;
                dc_q <= delay_count;
                wptr <= '0;
            end
            if (wr_en) wptr <= wptr + ADDR_W'(1);
            // readout starts at the newest written address
            if (rd_load) rptr <= wr_en ? wptr : wptr - ADDR_W'(1);
            if (rd_dec) rptr <= rptr - ADDR_W'(1);
            if (capture) tx_data <= mem_rdata;
        end
    end

    capture_counter #(.W(CNT_W)) u_delay_counter (
        .clock      (clock),
        .reset      (rst),
        .load       (dly_load),
        .load_value (dly_val),
        .dec        (dly_dec),
        .count      (dly_cnt),
        .zero       (dly_zero)
    );

    capture_counter #(.W(CNT_W)) u_read_counter (
        .clock      (clock),
        .reset      (rst),
        .load       (rd_load),
        .load_value (clamp_len(rc_q)),
        .dec        (rd_dec),
        .count      (rd_cnt),
        .zero       (rd_zero)
    );

    assign mem_we      = wr_en;
    assign mem_waddr   = wptr;
    assign mem_wdata   = sample_data;
    assign mem_raddr   = rptr;
    assign tx_valid    = (state == SEND);
    assign data_ready  = (state == READ_ADDR) || (state == READ_WAIT) || (state == SEND);
    assign arm_led     = (state == ARMED) || (state == DELAY);
    assign trigger_led = (state == DELAY) || data_ready;

endmodule

// File: tb/tb_capture_controller.sv
// Directed bench for capture_controller with a 16-word synchronous-read
// buffer model and ramp sample data.
module tb_capture_controller;

    localparam int AW = 4;
    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          reset, cmd_reset, cmd_run, sample_valid, trigger, tx_ready;
    logic [15:0]   read_count, delay_count;
    logic [DW-1:0] sample_data, mem_wdata, mem_rdata, tx_data;
    logic [AW-1:0] mem_waddr, mem_raddr;
    logic          mem_we, tx_valid, data_ready, arm_led, trigger_led;

    logic [DW-1:0] mem [16];
    int total = 0;
    int bad   = 0;
    int writes = 0;
    int base;
    int k;

    capture_controller #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock        (clock),
        .reset        (reset),
        .cmd_reset    (cmd_reset),
        .cmd_run      (cmd_run),
        .read_count   (read_count),
        .delay_count  (delay_count),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .trigger      (trigger),
        .mem_we       (mem_we),
        .mem_waddr    (mem_waddr),
        .mem_wdata    (mem_wdata),
        .mem_raddr    (mem_raddr),
        .mem_rdata    (mem_rdata),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_ready     (tx_ready),
        .data_ready   (data_ready),
        .arm_led      (arm_led),
        .trigger_led  (trigger_led)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
            writes <= writes + 1;
        end
        mem_rdata <= mem[mem_raddr];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic run_cmd;
        cmd_run = 1'b1;
        tick;
        cmd_run = 1'b0;
    endtask

    task automatic soft_reset;
        cmd_reset = 1'b1;
        tick;
        cmd_reset = 1'b0;
    endtask

    // Ramp samples (1,2,3..) every div+1 clocks; trigger on sample trig_at.
    task automatic run_capture(input int trig_at, input int div);
        int c;
        c = 0;
        k = 0;
        while (arm_led && c < 400) begin
            sample_valid = (c % (div + 1) == 0);
            if (sample_valid) begin
                k++;
                sample_data = k;
            end
            trigger = sample_valid && (k == trig_at);
            tick;
            c++;
        end
        sample_valid = 1'b0;
        trigger      = 1'b0;
        check("capture_done", 32'(arm_led), 32'd0);
    endtask

    // Accept n words, expecting first_word, first_word-1, ...; stall on word stall_at.
    task automatic read_out(input int n, input int first_word, input int stall_at);
        for (int i = 0; i < n; i++) begin
            int w;
            w = 0;
            while (!tx_valid && w < 20) begin
                tick;
                w++;
            end
            check($sformatf("tx_valid_w%0d", i), 32'(tx_valid), 32'd1);
            check($sformatf("data_ready_w%0d", i), 32'(data_ready), 32'd1);
            if (i == stall_at) begin
                for (int s = 0; s < 20; s++) begin
                    tick;
                    check("stall_valid", 32'(tx_valid), 32'd1);
                    check("stall_data", tx_data, 32'(first_word - i));
                end
            end
            check($sformatf("word%0d", i), tx_data, 32'(first_word - i));
            tx_ready = 1'b1;
            tick;
            tx_ready = 1'b0;
        end
        check("data_ready_after_last", 32'(data_ready), 32'd0);
        check("tx_valid_after_last", 32'(tx_valid), 32'd0);
    endtask

    initial begin
        int w;
        reset = 1'b1; cmd_reset = 1'b0; cmd_run = 1'b0;
        sample_valid = 1'b0; trigger = 1'b0; tx_ready = 1'b0;
        sample_data = '0; read_count = '0; delay_count = '0;
        repeat (3) tick;
        reset = 1'b0;
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_data_ready", 32'(data_ready), 32'd0);
        check("rst_arm_led", 32'(arm_led), 32'd0);
        check("rst_trigger_led", 32'(trigger_led), 32'd0);
        check("rst_waddr", 32'(mem_waddr), 32'd0);
        check("rst_raddr", 32'(mem_raddr), 32'd0);
        check("rst_tx_data", tx_data, 32'd0);

        // basic capture: 4 post-trigger samples, 8 words newest first
        read_count = 16'd1; delay_count = 16'd0;
        base = writes;
        run_cmd;
        check("t1_armed", 32'(arm_led), 32'd1);
        run_capture(10, 0);
        check("t1_writes", 32'(writes - base), 32'd13);
        check("t1_waddr", 32'(mem_waddr), 32'd13);
        check("t1_trigger_led", 32'(trigger_led), 32'd1);
        read_out(8, 13, 2);
        sample_valid = 1'b1;
        #1;
        check("idle_no_write", 32'(mem_we), 32'd0);
        sample_valid = 1'b0;

        // clamped readout wrapping through address 0, sparse samples
        read_count = 16'hFFFF; delay_count = 16'd0;
        base = writes;
        run_cmd;
        run_capture(20, 2);
        check("t2_writes", 32'(writes - base), 32'd23);
        check("t2_waddr", 32'(mem_waddr), 32'd7);
        read_out(16, 23, -1);

        // trigger in IDLE ignored
        trigger = 1'b1;
        tick;
        trigger = 1'b0;
        check("idle_trig_arm", 32'(arm_led), 32'd0);
        check("idle_trig_led", 32'(trigger_led), 32'd0);

        // soft reset during DELAY
        read_count = 16'd0; delay_count = 16'd3;
        run_cmd;
        for (int s = 1; s <= 4; s++) begin
            sample_valid = 1'b1;
            sample_data  = s;
            trigger      = (s == 4);
            tick;
        end
        sample_valid = 1'b0; trigger = 1'b0;
        check("t3_delay_led", 32'(trigger_led), 32'd1);
        run_cmd;
        check("t3_run_in_delay_arm", 32'(arm_led), 32'd1);
        check("t3_run_in_delay_trig", 32'(trigger_led), 32'd1);
        check("t3_run_in_delay_waddr", 32'(mem_waddr), 32'd4);
        soft_reset;
        check("t3_rst_arm", 32'(arm_led), 32'd0);
        check("t3_rst_trig", 32'(trigger_led), 32'd0);
        check("t3_rst_waddr", 32'(mem_waddr), 32'd0);
        check("t3_rst_ready", 32'(data_ready), 32'd0);

        // soft reset during SEND
        read_count = 16'd0; delay_count = 16'd0;
        run_cmd;
        check("t4_armed", 32'(arm_led), 32'd1);
        run_capture(5, 0);
        w = 0;
        while (!tx_valid && w < 20) begin
            tick;
            w++;
        end
        check("t4_first_word", tx_data, 32'd8);
        run_cmd;
        check("t4_run_in_send_valid", 32'(tx_valid), 32'd1);
        check("t4_run_in_send_data", tx_data, 32'd8);
        soft_reset;
        check("t4_rst_valid", 32'(tx_valid), 32'd0);
        check("t4_rst_data", tx_data, 32'd0);
        check("t4_rst_ready", 32'(data_ready), 32'd0);
        check("t4_rst_raddr", 32'(mem_raddr), 32'd0);
        check("t4_rst_trig", 32'(trigger_led), 32'd0);

        // reset wins over run; then a plain run arms again
        cmd_reset = 1'b1; cmd_run = 1'b1;
        tick;
        cmd_reset = 1'b0; cmd_run = 1'b0;
        check("rst_and_run", 32'(arm_led), 32'd0);
        run_cmd;
        check("run_after_reset", 32'(arm_led), 32'd1);
        soft_reset;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
